// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a four-digit multiplexed seven-segment bus: filters
// the scan lines, assembles a frame aligned to the leftmost digit, decodes hex.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [31:0] pattern,
    output logic [15:0] hex,
    output logic [3:0]  dp,
    output logic [3:0]  hex_ok,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        an_error
);

    typedef enum logic [1:0] {
        ALIGN,
        COLLECT,
        COMMIT
    } state_t;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    logic [7:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [3:0]  an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [7:0]  settle_q, settle_d;
    logic        accept_q, accept_d;
    state_t      state_q, state_d;
    logic [3:0]  seen_q, seen_d;
    logic [31:0] frame_q, frame_d;
    logic [31:0] pattern_q, pattern_d;
    logic [15:0] hex_q, hex_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  hex_ok_q, hex_ok_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_changed_q, frame_changed_d;
    logic        an_error_q, an_error_d;
    logic        have_prev_q, have_prev_d;

    logic [3:0]  an_low;
    logic        one_low;
    logic        sample_cap;
    logic        sample_bad;
    logic [1:0]  cap_digit;
    logic [3:0]  cap_bit;
    logic [15:0] dec_hex;
    logic [3:0]  dec_ok;
    logic [3:0]  dec_dp;

    // Returns {match, nibble}; bit 7 (DP) is never part of the lookup.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // The counter compares the word entering the second stage with the one in it,
    // so it reads 0 on the first cycle a new synchronized word is visible.
    always_comb begin
        seg_s1_d = seg_in;
        an_s1_d  = an_in;
        seg_s2_d = seg_s1_q;
        an_s2_d  = an_s1_q;
        if ({an_s1_q, seg_s1_q} != {an_s2_q, seg_s2_q}) begin
            settle_d = 8'd0;
        end else if (settle_q != SETTLE) begin
            settle_d = settle_q + 8'd1;
        end else begin
            settle_d = settle_q;
        end
        accept_d = (settle_d == SETTLE) && (settle_q != SETTLE);
    end

    always_comb begin
        an_low     = ~an_s2_q;
        one_low    = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
        sample_cap = accept_q && one_low;
        sample_bad = accept_q && (an_low != 4'd0) && !one_low;
        case (an_low)
            4'b0010: cap_digit = 2'd1;
            4'b0100: cap_digit = 2'd2;
            4'b1000: cap_digit = 2'd3;
            default: cap_digit = 2'd0;
        endcase
        cap_bit = 4'b0001 << cap_digit;
    end

    always_comb begin
        dec_hex = '0;
        dec_ok  = '0;
        dec_dp  = '0;
        for (int i = 0; i < 4; i++) begin
            {dec_ok[i], dec_hex[4*i +: 4]} = decode_seg(frame_q[8*i +: 7]);
            dec_dp[i] = ~frame_q[8*i + 7];
        end
    end

    always_comb begin
        state_d         = state_q;
        seen_d          = seen_q;
        frame_d         = frame_q;
        pattern_d       = pattern_q;
        hex_d           = hex_q;
        dp_d            = dp_q;
        hex_ok_d        = hex_ok_q;
        frame_valid_d   = 1'b0;
        frame_changed_d = 1'b0;
        have_prev_d     = have_prev_q;
        an_error_d      = sample_bad;
        unique case (state_q)
            ALIGN: begin
                if (sample_cap && cap_digit == 2'd3) begin
                    frame_d[31:24] = seg_s2_q;
                    seen_d         = 4'b1000;
                    state_d        = COLLECT;
                end
            end
            COLLECT: begin
                if (sample_cap) begin
                    frame_d[{cap_digit, 3'b000} +: 8] = seg_s2_q;
                    // A fresh leftmost digit means the scan restarted mid-frame.
                    if (cap_digit == 2'd3) begin
                        seen_d = 4'b1000;
                    end else begin
                        seen_d = seen_q | cap_bit;
                        if ((seen_q | cap_bit) == 4'hF) begin
                            state_d = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
                pattern_d       = frame_q;
                hex_d           = dec_hex;
                dp_d            = dec_dp;
                hex_ok_d        = dec_ok;
                frame_valid_d   = 1'b1;
                frame_changed_d = !have_prev_q || (frame_q != pattern_q);
                have_prev_d     = 1'b1;
                seen_d          = 4'd0;
                state_d         = ALIGN;
            end
            default: state_d = ALIGN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1_q        <= 8'hFF;
            seg_s2_q        <= 8'hFF;
            an_s1_q         <= 4'hF;
            an_s2_q         <= 4'hF;
            settle_q        <= 8'd0;
            accept_q        <= 1'b0;
            state_q         <= ALIGN;
            seen_q          <= 4'd0;
            frame_q         <= 32'd0;
            pattern_q       <= 32'd0;
            hex_q           <= 16'd0;
            dp_q            <= 4'd0;
            hex_ok_q        <= 4'd0;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            an_error_q      <= 1'b0;
            have_prev_q     <= 1'b0;
        end else begin
            seg_s1_q        <= seg_s1_d;
            seg_s2_q        <= seg_s2_d;
            an_s1_q         <= an_s1_d;
            an_s2_q         <= an_s2_d;
            settle_q        <= settle_d;
            accept_q        <= accept_d;
            state_q         <= state_d;
            seen_q          <= seen_d;
            frame_q         <= frame_d;
            pattern_q       <= pattern_d;
            hex_q           <= hex_d;
            dp_q            <= dp_d;
            hex_ok_q        <= hex_ok_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
            an_error_q      <= an_error_d;
            have_prev_q     <= have_prev_d;
        end
    end

    assign pattern       = pattern_q;
    assign hex           = hex_q;
    assign dp            = dp_q;
    assign hex_ok        = hex_ok_q;
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign an_error      = an_error_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the four-digit multiplexed seven-segment driver. Samples the active-low `seg`/`an` scan lines, rejects transitional samples with a settle filter, collects one pattern per digit into a frame aligned to the leftmost digit, and decodes each pattern to a hex nibble. Used as a board self-test and loopback monitor of the display bus, and as a bench checker for display drivers.

## Interface
- `SETTLE_CYCLES`, default 16: consecutive `clk` cycles the synchronized `{an_in, seg_in}` must be unchanged before a sample is accepted (range 2..255).
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: synchronous, active-high reset.
- `seg_in` input 8: active-low segments. Bit 0 = A, 1 = B, 2 = C, 3 = D, 4 = E, 5 = F, 6 = G, 7 = DP.
- `an_in` input 4: active-low anodes. `an_in[3]` = leftmost digit (digit 3), `an_in[0]` = rightmost.
- `pattern` output 32: raw committed frame; digit *n* in `[8n+7:8n]`.
- `hex` output 16: decoded nibbles; digit *n* in `[4n+3:4n]`.
- `dp` output 4: decimal point on (bit 7 of the pattern was 0) per digit.
- `hex_ok` output 4: the pattern bits 6:0 matched a table entry, per digit.
- `frame_valid` output 1: 1-cycle pulse when a new frame is committed.
- `frame_changed` output 1: 1-cycle pulse, coincident with `frame_valid`, when the new `pattern` differs from the previous committed one.
- `an_error` output 1: 1-cycle pulse when an accepted sample has more than one anode low.

## Operation
- Reset: all outputs 0; synchronizers are loaded with 8'hFF/4'hF; settle counter 0; `seen` 0; FSM in ALIGN.
- Synchronizer: two flops on `seg_in` and `an_in`.
- Settle counter: cleared when the synchronized word differs from the previous cycle's word. Otherwise it increments and saturates at `SETTLE_CYCLES`. A sample is accepted exactly once per stable interval, on the cycle the counter reaches `SETTLE_CYCLES`.
- Accepted sample classification:
  - `an` = 4'hF: blank. Ignored, no error.
  - Exactly one bit of `an` is 0: capture into that digit.
  - Any other value: `an_error` pulses and the sample is discarded. The FSM state is unchanged.
- FSM states:
  - ALIGN: waits for a capture of digit 3, then stores it, sets `seen` = 4'b1000 and moves to COLLECT. Captures of other digits are ignored.
  - COLLECT: each capture writes its slot and sets its `seen` bit. A repeat capture of an already-seen digit overwrites that slot. A capture of digit 3 while `seen` ≠ 4'hF restarts the frame: `seen` = 4'b1000 and slot 3 is overwritten. When `seen` becomes 4'hF, the FSM moves to COMMIT.
  - COMMIT (1 cycle): updates `pattern`, `hex`, `dp` and `hex_ok`; pulses `frame_valid`; pulses `frame_changed` if warranted; clears `seen`; returns to ALIGN.
- Decode table on bits 6:0 → nibble:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Bit 7 is excluded. No match gives nibble 0 with `hex_ok` = 0.
- The first frame after reset always pulses `frame_changed`, because the previous frame is tracked as "none".
- Reset mid-frame discards the partial frame. Committed outputs return to 0.

## Timing
- Input to stable synchronized word: 2 cycles.
- Sample accepted `SETTLE_CYCLES` cycles after the synchronized word last changed.
- The capture registers the slot on the cycle after acceptance.
- The COMMIT outputs and `frame_valid` appear 1 cycle after the capture that completes `seen`. All outputs are registered.
- Inputs that toggle more often than every `SETTLE_CYCLES` + 1 cycles are never accepted. There is no error for this case.
- `an_error` is registered 1 cycle after acceptance.

## Test plan
- Scan at a 500 Hz digit rate (200 000 cycles per digit), `SETTLE_CYCLES` = 16, order 0111/92, 1011/30, 1101/F9, 1110/82. Required:
  - First commit: `hex` = 16'h5316, `dp` = 4'b0100, `hex_ok` = 4'hF, `pattern` = 32'h9230F982, `frame_changed` = 1.
  - Second identical frame: `frame_valid` = 1, `frame_changed` = 0.
- Start the scan on digit 1 (1101/F9, 1110/82, 0111/92, …). Required: digits 1 and 0 are ignored in ALIGN. The first commit occurs only after the full sequence that begins with 0111 and still yields 16'h5316.
- Glitch: insert a 10-cycle 1011/00 pulse between digits. Required: it is not accepted and the frame is unchanged. Repeat with a 20-cycle pulse: required `pattern[23:16]` = 8'h00, `hex[11:8]` = 8.
- Anodes 0011 held for 40 cycles. Required: a single `an_error` pulse and no `seen` change. Anodes 1111 held: no error, no capture.
- Digit 2 pattern 8'hFF (all off). Required: `hex_ok` = 4'b1011, `hex[11:8]` = 0.
- Assert `rst` for 1 cycle with `seen` = 4'b1100 after a prior commit. Required: next cycle all outputs 0, FSM in ALIGN. The next full frame commits with `frame_changed` = 1.
